// File: rtl/ram64_seq_ctrl_pkg.sv
// Shared definitions for the RAM64 sequencing controller: widths, op codes,
// state encoding and the count clamp.
package ram64_seq_defs;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;
  localparam int DEPTH  = 64;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_SCAN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Requests beyond the memory depth touch every word exactly once.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
  endfunction

endpackage

// File: rtl/ram64_seq_ctrl_addrgen.sv
// Index / wrapped-address / running-value generator shared by FILL, SCAN and
// VERIFY; the value is built incrementally (seed + i*step) with one adder.
module ram64_seq_addrgen
  import ram64_seq_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              restart,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [WORD_W-1:0] seed,
  input  logic [WORD_W-1:0] step,
  output logic [CNT_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] value
);

  logic [ADDR_W-1:0] base_reg;
  logic [WORD_W-1:0] seed_reg;
  logic [WORD_W-1:0] step_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] value_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_reg  <= '0;
      seed_reg  <= '0;
      step_reg  <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      value_reg <= '0;
    end else if (load) begin
      base_reg  <= base;
      seed_reg  <= seed;
      step_reg  <= step;
      idx_reg   <= '0;
      addr_reg  <= base;
      value_reg <= seed;
    end else if (restart) begin
      // Second walk over the same run (verify pass) starts from the captured command.
      idx_reg   <= '0;
      addr_reg  <= base_reg;
      value_reg <= seed_reg;
    end else if (adv) begin
      idx_reg   <= idx_reg + 7'd1;
      addr_reg  <= addr_reg + 6'd1;
      value_reg <= value_reg + step_reg;
    end
  end

  assign idx   = idx_reg;
  assign addr  = addr_reg;
  assign value = value_reg;

endmodule

// File: rtl/ram64_seq_ctrl.sv
// Block-initialise / block-checksum engine in front of RAM64.
// Optional read-back verify pass after FILL is enabled by RAM_SEQ_VERIFY_EN.
module ram64_seq_ctrl
  import ram64_seq_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  input  logic [WORD_W-1:0] seed,
  input  logic [WORD_W-1:0] step,
  output logic [WORD_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [WORD_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] sum
`ifdef RAM_SEQ_VERIFY_EN
  ,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
`endif
);

  state_t            state_reg;
  state_t            state_next;
  logic              op_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [WORD_W-1:0] acc_reg;
  logic [WORD_W-1:0] sum_reg;

  logic              ag_load;
  logic              ag_restart;
  logic              ag_adv;
  logic [CNT_W-1:0]  ag_idx;
  logic [ADDR_W-1:0] ag_addr;
  logic [WORD_W-1:0] ag_value;
  logic              last;

  ram64_seq_addrgen u_addrgen (
    .clock   (clock),
    .reset   (reset),
    .load    (ag_load),
    .restart (ag_restart),
    .adv     (ag_adv),
    .base    (base),
    .seed    (seed),
    .step    (step),
    .idx     (ag_idx),
    .addr    (ag_addr),
    .value   (ag_value)
  );

  assign last = (ag_idx == count_reg - 7'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ag_load    = 1'b0;
    ag_restart = 1'b0;
    ag_adv     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          if (count == '0)         state_next = ST_DONE;
          else if (op == OP_SCAN)  state_next = ST_SCAN;
          else                     state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last) begin
`ifdef RAM_SEQ_VERIFY_EN
          state_next = ST_VERIFY;
          ag_restart = 1'b1;
`else
          state_next = ST_DONE;
`endif
        end else begin
          ag_adv = 1'b1;
        end
      end
      ST_SCAN: begin
        if (last) state_next = ST_DONE;
        else      ag_adv     = 1'b1;
      end
`ifdef RAM_SEQ_VERIFY_EN
      ST_VERIFY: begin
        if (last) state_next = ST_DONE;
        else      ag_adv     = 1'b1;
      end
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_load    = (state_reg == ST_FILL);
    ram_in      = (state_reg == ST_FILL) ? ag_value : '0;
    ram_address = '0;
    if (state_reg == ST_FILL || state_reg == ST_SCAN || state_reg == ST_VERIFY)
      ram_address = ag_addr;
    busy = (state_reg != ST_IDLE);
    done = (state_reg == ST_DONE);
    sum  = sum_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_reg    <= OP_FILL;
      count_reg <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        op_reg    <= op;
        count_reg <= clamp_count(count);
        acc_reg   <= '0;
      end
      if (state_reg == ST_SCAN)
        acc_reg <= acc_reg + ram_out;
      if (state_reg == ST_DONE && op_reg == OP_SCAN)
        sum_reg <= acc_reg;
    end
  end

`ifdef RAM_SEQ_VERIFY_EN
  logic              err_reg;
  logic [ADDR_W-1:0] err_addr_reg;

  // Only the first mismatch of a pass is recorded; a new command clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else if (state_reg == ST_VERIFY && !err_reg && ram_out != ag_value) begin
      err_reg      <= 1'b1;
      err_addr_reg <= ag_addr;
    end
  end

  assign err      = err_reg;
  assign err_addr = err_addr_reg;
`endif

endmodule

// File: tb/tb_ram64_seq_ctrl.sv
// Self-checking bench for ram64_seq_ctrl with a behavioural RAM64 and a
// word-array reference model; build with RAM_SEQ_VERIFY_EN to cover verify.
module tb_ram64_seq_ctrl;

`ifdef RAM_SEQ_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [5:0]  base;
  logic [6:0]  count;
  logic [15:0] seed;
  logic [15:0] step;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic [15:0] ram_out;
  logic        busy;
  logic        done;
  logic [15:0] sum;
`ifdef RAM_SEQ_VERIFY_EN
  logic        err;
  logic [5:0]  err_addr;
`endif

  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];
  logic        mem_init;
  logic        corrupt_en;
  logic [5:0]  corrupt_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int idle_bad = 0;
  logic [15:0] exp_sum;

  ram64_seq_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .base        (base),
    .count       (count),
    .seed        (seed),
    .step        (step),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out),
    .busy        (busy),
    .done        (done),
    .sum         (sum)
`ifdef RAM_SEQ_VERIFY_EN
    ,
    .err         (err),
    .err_addr    (err_addr)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural RAM64: combinational read, write on the rising edge.
  assign ram_out = mem[ram_address];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 37 + 11);
    end else if (ram_load) begin
      mem[ram_address] <= (corrupt_en && ram_address == corrupt_addr) ? (ram_in ^ 16'h0001) : ram_in;
    end
  end

  function automatic int eff_n(input logic [6:0] c);
    return (c > 7'd64) ? 64 : int'(c);
  endfunction

  function automatic int busy_cycles(input logic o, input logic [6:0] c);
    return (o == 1'b0 && VERIFY_ON) ? 2 * eff_n(c) : eff_n(c);
  endfunction

  function automatic void model_fill(input logic [5:0] b, input int n, input logic [15:0] sd, input logic [15:0] st);
    for (int i = 0; i < n; i++) ref_mem[(int'(b) + i) % 64] = 16'(int'(sd) + i * int'(st));
  endfunction

  function automatic logic [15:0] model_scan(input logic [5:0] b, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(ref_mem[(int'(b) + i) % 64]);
    return 16'(s);
  endfunction

  function automatic int mem_first_diff();
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) return i;
    return -1;
  endfunction

  task automatic run_cmd(input logic o, input logic [5:0] b, input logic [6:0] c,
                         input logic [15:0] sd, input logic [15:0] st, input int busy_at,
                         output int loads, output int dones, output int done_cyc, output int idle_cyc);
    loads = 0; dones = 0; done_cyc = -1; idle_cyc = -1;
    @(negedge clock);
    start = 1'b1; op = o; base = b; count = c; seed = sd; step = st;
    @(posedge clock);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clock);
      if (ram_load) loads++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!ram_load && ram_in !== 16'h0) idle_bad++;
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      start = (cyc == busy_at);
      op    = 1'($urandom);
      base  = 6'($urandom);
      count = 7'($urandom_range(1, 64));
      seed  = 16'($urandom);
      step  = 16'($urandom);
    end
    start = 1'b0;
    $display("txn op=%0d base=%0d count=%0d seed=%h step=%h loads=%0d dones=%0d done_cyc=%0d idle_cyc=%0d sum=%h",
             o, b, c, sd, st, loads, dones, done_cyc, idle_cyc, sum);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1; corrupt_en = 1'b0; corrupt_addr = '0;
    start = 1'b0; op = 1'b0; base = '0; count = '0; seed = '0; step = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'(i * 37 + 11);
    exp_sum = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (ram_load !== 1'b0 || ram_address !== 6'd0 || ram_in !== 16'd0) begin
      n_fail++; $display("FAIL reset_ram_if: load=%b addr=%0d in=%h required 0/0/0", ram_load, ram_address, ram_in);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b required 0/0", busy, done);
    end
    n_checks++;
    if (sum !== 16'h0) begin
      n_fail++; $display("FAIL reset_sum: got %h required 0000", sum);
    end
`ifdef RAM_SEQ_VERIFY_EN
    n_checks++;
    if (err !== 1'b0 || err_addr !== 6'd0) begin
      n_fail++; $display("FAIL reset_err: err=%b addr=%0d required 0/0", err, err_addr);
    end
`endif
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_fill();
    int loads, dones, dc, ic;
    run_cmd(1'b0, 6'd16, 7'd4, 16'd15, 16'd1, 0, loads, dones, dc, ic);
    model_fill(6'd16, 4, 16'd15, 16'd1);
    n_checks++;
    if (loads !== 4) begin n_fail++; $display("FAIL basic_loads: got %0d required 4", loads); end
    n_checks++;
    if (dones !== 1 || dc !== busy_cycles(1'b0, 7'd4) + 1) begin
      n_fail++; $display("FAIL basic_done: count=%0d cycle=%0d required 1/%0d", dones, dc, busy_cycles(1'b0, 7'd4) + 1);
    end
    n_checks++;
    if (ic !== busy_cycles(1'b0, 7'd4) + 2) begin
      n_fail++; $display("FAIL basic_busy_fall: got cycle %0d required %0d", ic, busy_cycles(1'b0, 7'd4) + 2);
    end
    n_checks++;
    if (mem[16] !== 16'd15 || mem[17] !== 16'd16 || mem[18] !== 16'd17 || mem[19] !== 16'd18) begin
      n_fail++; $display("FAIL basic_words: got %0d %0d %0d %0d required 15 16 17 18", mem[16], mem[17], mem[18], mem[19]);
    end
    n_checks++;
    if (mem_first_diff() != -1) begin
      n_fail++; $display("FAIL basic_mem: word %0d differs from model", mem_first_diff());
    end
  endtask

  task automatic test_wrap();
    int loads, dones, dc, ic;
    run_cmd(1'b0, 6'd62, 7'd4, 16'd100, 16'd10, 0, loads, dones, dc, ic);
    model_fill(6'd62, 4, 16'd100, 16'd10);
    n_checks++;
    if (mem[62] !== 16'd100 || mem[63] !== 16'd110 || mem[0] !== 16'd120 || mem[1] !== 16'd130) begin
      n_fail++; $display("FAIL wrap_words: got %0d %0d %0d %0d required 100 110 120 130", mem[62], mem[63], mem[0], mem[1]);
    end
    n_checks++;
    if (sum !== exp_sum) begin n_fail++; $display("FAIL wrap_sum_held: got %h required %h", sum, exp_sum); end
    run_cmd(1'b1, 6'd62, 7'd4, 16'd0, 16'd0, 0, loads, dones, dc, ic);
    exp_sum = model_scan(6'd62, 4);
    n_checks++;
    if (sum !== 16'd460) begin n_fail++; $display("FAIL wrap_sum: got %0d required 460", sum); end
    n_checks++;
    if (loads !== 0 || dc !== 5) begin
      n_fail++; $display("FAIL wrap_scan_timing: loads=%0d done_cyc=%0d required 0/5", loads, dc);
    end
  endtask

  task automatic test_overflow();
    int loads, dones, dc, ic;
    run_cmd(1'b0, 6'd0, 7'd64, 16'hFFFF, 16'h0, 0, loads, dones, dc, ic);
    model_fill(6'd0, 64, 16'hFFFF, 16'h0);
    n_checks++;
    if (loads !== 64) begin n_fail++; $display("FAIL ovf_loads: got %0d required 64", loads); end
    run_cmd(1'b1, 6'($urandom), 7'd64, 16'h0, 16'h0, 0, loads, dones, dc, ic);
    exp_sum = 16'hFFC0;
    n_checks++;
    if (sum !== 16'hFFC0) begin n_fail++; $display("FAIL ovf_sum: got %h required ffc0", sum); end
    // Count above the depth is clamped to 64 words.
    run_cmd(1'b1, 6'd7, 7'd100, 16'h0, 16'h0, 0, loads, dones, dc, ic);
    n_checks++;
    if (sum !== 16'hFFC0 || dc !== 65) begin
      n_fail++; $display("FAIL clamp_scan: sum=%h done_cyc=%0d required ffc0/65", sum, dc);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int loads, dones, dc, ic;
    run_cmd(1'b0, 6'd5, 7'd0, 16'h1234, 16'h1, 1, loads, dones, dc, ic);
    n_checks++;
    if (loads !== 0 || dones !== 1 || dc !== 1 || ic !== 2) begin
      n_fail++; $display("FAIL zero_count: loads=%0d dones=%0d done_cyc=%0d idle=%0d required 0/1/1/2", loads, dones, dc, ic);
    end
    n_checks++;
    if (mem_first_diff() != -1) begin
      n_fail++; $display("FAIL zero_mem: word %0d changed", mem_first_diff());
    end
    run_cmd(1'b1, 6'd60, 7'd10, 16'h0, 16'h0, 3, loads, dones, dc, ic);
    exp_sum = model_scan(6'd60, 10);
    n_checks++;
    if (sum !== exp_sum || loads !== 0 || dones !== 1 || ic !== 12) begin
      n_fail++; $display("FAIL busy_start: sum=%h loads=%0d dones=%0d idle=%0d required %h/0/1/12", sum, loads, dones, ic, exp_sum);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] sd, st;
    sd = 16'($urandom); st = 16'($urandom);
    @(negedge clock);
    start = 1'b1; op = 1'b0; base = 6'd40; count = 7'd8; seed = sd; step = st;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ram_load !== 1'b0 || busy !== 1'b0 || ram_address !== 6'd0) begin
      n_fail++; $display("FAIL abort_outputs: load=%b busy=%b addr=%0d required 0/0/0", ram_load, busy, ram_address);
    end
    @(negedge clock);
    reset = 1'b0;
    model_fill(6'd40, 2, sd, st);
    exp_sum = 16'h0;
    @(negedge clock);
    n_checks++;
    if (mem_first_diff() != -1) begin
      n_fail++; $display("FAIL abort_mem: word %0d got %h required %h", mem_first_diff(),
                         mem[mem_first_diff()], ref_mem[mem_first_diff()]);
    end
    n_checks++;
    if (sum !== 16'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_status: sum=%h done=%b required 0000/0", sum, done);
    end
  endtask

  task automatic test_random();
    int loads, dones, dc, ic, n, ec;
    logic o; logic [5:0] b; logic [6:0] c; logic [15:0] sd, st;
    for (int it = 0; it < 14; it++) begin
      o = 1'($urandom); b = 6'($urandom); c = 7'($urandom_range(0, 70));
      sd = 16'($urandom); st = 16'($urandom);
      run_cmd(o, b, c, sd, st, $urandom_range(0, 4), loads, dones, dc, ic);
      n = eff_n(c);
      ec = busy_cycles(o, c);
      if (o == 1'b0) model_fill(b, n, sd, st);
      else           exp_sum = model_scan(b, n);
      n_checks++;
      if (loads !== ((o == 1'b0) ? n : 0) || dones !== 1) begin
        n_fail++; $display("FAIL rand_activity[%0d]: loads=%0d dones=%0d required %0d/1", it, loads, dones, (o == 1'b0) ? n : 0);
      end
      n_checks++;
      if (dc !== ec + 1 || ic !== ec + 2) begin
        n_fail++; $display("FAIL rand_timing[%0d]: done_cyc=%0d idle=%0d required %0d/%0d", it, dc, ic, ec + 1, ec + 2);
      end
      n_checks++;
      if (sum !== exp_sum) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h required %h", it, sum, exp_sum); end
      n_checks++;
      if (mem_first_diff() != -1) begin
        n_fail++; $display("FAIL rand_mem[%0d]: word %0d differs from model", it, mem_first_diff());
      end
    end
    n_checks++;
    if (idle_bad !== 0) begin n_fail++; $display("FAIL ram_in_idle: %0d cycles nonzero required 0", idle_bad); end
  endtask

`ifdef RAM_SEQ_VERIFY_EN
  task automatic test_verify();
    int loads, dones, dc, ic;
    logic [15:0] sd, st;
    sd = 16'($urandom); st = 16'($urandom);
    corrupt_en = 1'b1; corrupt_addr = 6'd5;
    run_cmd(1'b0, 6'd0, 7'd8, sd, st, 0, loads, dones, dc, ic);
    corrupt_en = 1'b0;
    model_fill(6'd0, 8, sd, st);
    ref_mem[5] = ref_mem[5] ^ 16'h0001;
    n_checks++;
    if (err !== 1'b1 || err_addr !== 6'd5) begin
      n_fail++; $display("FAIL verify_err: err=%b addr=%0d required 1/5", err, err_addr);
    end
    n_checks++;
    if (dc !== 17) begin n_fail++; $display("FAIL verify_timing: done_cyc=%0d required 17", dc); end
    run_cmd(1'b0, 6'd0, 7'd8, sd, st, 0, loads, dones, dc, ic);
    model_fill(6'd0, 8, sd, st);
    n_checks++;
    if (err !== 1'b0 || mem_first_diff() != -1) begin
      n_fail++; $display("FAIL verify_clear: err=%b diff=%0d required 0/-1", err, mem_first_diff());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_overflow();
    test_zero_and_busy_start();
    test_reset_mid_fill();
    test_random();
`ifdef RAM_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram64_seq_ctrl.md
# ram64_seq_ctrl

Sequencing controller that sits directly upstream of the 64-word RAM64 and drives its `in`, `load` and `address` inputs. It also consumes its `out` word. On a single start pulse it either fills a run of consecutive words with an arithmetic sequence, or scans a run and returns the 16-bit sum. It is the block-initialise / block-checksum engine for the 64-word memory stage.

## Interface
Parameters:
- none; widths are fixed by RAM64 (16-bit word, 6-bit address).

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = FILL, 1 = SCAN; captured with `start`.
- `base`  in  6  first RAM address; captured with `start`.
- `count`  in  7  number of words, 0..64; captured with `start`.
- `seed`  in  16  first FILL value; captured with `start`.
- `step`  in  16  FILL increment; captured with `start`.
- `ram_in`  out  16  to RAM64 `in`.
- `ram_load`  out  1  to RAM64 `load`.
- `ram_address`  out  6  to RAM64 `address`.
- `ram_out`  in  16  from RAM64 `out`; combinational read of `ram_address`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `sum`  out  16  SCAN result; held until the next SCAN completes.
- `err`  out  1  verify mismatch flag (only with `RAM_SEQ_VERIFY_EN`).
- `err_addr`  out  6  address of the first mismatch (only with `RAM_SEQ_VERIFY_EN`).

## Operation
- States: IDLE, FILL, SCAN, VERIFY (macro only), DONE.
- IDLE: on `start` = 1, capture all command fields, set index i = 0 and accumulator = 0.
  - `count` = 0 goes to DONE.
  - Otherwise go to FILL when `op` = 0, or SCAN when `op` = 1.
- FILL: `ram_load` = 1, `ram_address` = (base + i) mod 64, `ram_in` = seed + i·step mod 2^16. Increment i each cycle. After i = count-1, go to VERIFY (macro) or DONE.
- SCAN: `ram_load` = 0, `ram_address` = (base + i) mod 64. Each cycle, accumulator += `ram_out` mod 2^16. After the last word, go to DONE.
- DONE: `done` = 1 for exactly one cycle. `sum` is loaded from the accumulator (SCAN only), then go to IDLE.
- Address arithmetic wraps modulo 64. Example: base = 62, count = 4 touches addresses 62, 63, 0, 1.
- `count` > 64 is clamped to 64.
- `start` while `busy` is ignored. The captured command is unaffected.
- `ram_load` is 0 in every state except FILL. `ram_in` = 0 outside FILL.

## Timing
- Reset values (immediate, asynchronous): state = IDLE, `ram_load` = 0, `ram_address` = 0, `ram_in` = 0, `busy` = 0, `done` = 0, `sum` = 0, `err` = 0, `err_addr` = 0.
- Reset asserted mid-command aborts the command. `ram_load` falls without waiting for a clock edge. RAM contents already written remain.
- Start at edge k: FILL/SCAN occupies cycles k+1 .. k+N; `done` is high in cycle k+N+1; `busy` falls at edge k+N+2.
- With verify enabled, FILL is followed by N VERIFY cycles, so `done` is high in cycle k+2N+1.
- `count` = 0: `done` is high in cycle k+1, with no RAM activity.
- A new `start` is accepted in the cycle `busy` is low, i.e. no earlier than edge k+N+2.
- RAM writes commit on the rising edge that ends each FILL cycle.

## Configuration
- Macro: `RAM_SEQ_VERIFY_EN`.
- Defined:
  - After FILL, a VERIFY pass re-walks the same N addresses with `ram_load` = 0.
  - It regenerates the expected value seed + i·step and compares it with `ram_out`.
  - The first mismatch sets `err` = 1 and `err_addr`.
  - `err` and `err_addr` are sticky until the next accepted `start`, which clears both.
- Undefined:
  - No VERIFY state.
  - The `err` and `err_addr` ports are absent.
  - FILL goes straight to DONE.

## Structure
- Shared package/header `ram64_seq_defs`: state encoding constants, word width 16, address width 6, depth 64, op codes FILL = 0 / SCAN = 1.
- One natural sub-module: `ram64_seq_addrgen`. It holds index i, the wrapped address and the running value seed + i·step (add `step` each cycle, no multiplier), and is shared by FILL and VERIFY.

## Test plan
- Reset, then FILL base = 16, count = 4, seed = 15, step = 1 → RAM[16..19] = 15, 16, 17, 18; `ram_load` high for exactly 4 cycles; one `done` pulse.
- Wrap: FILL base = 62, count = 4, seed = 100, step = 10; then SCAN same range → addresses 62, 63, 0, 1 written with 100, 110, 120, 130; `sum` = 460.
- Overflow: FILL all 64 words with seed = 0xFFFF, step = 0, then SCAN count = 64 → `sum` = 0xFFC0.
- `count` = 0 and a `start` pulsed while busy → no RAM writes; a single `done` one cycle after the accepted start; the busy-time start has no effect.
- Reset asserted during FILL at i = 2 of count = 8 → `ram_load` = 0 immediately, `busy` = 0; only the first 2 words changed.
- Verify build: a bench model corrupts RAM[5] during FILL base = 0, count = 8 → `err` = 1, `err_addr` = 5; a subsequent clean FILL clears `err` to 0.
